dm_load_responder: RTL and testbench

//  Memory-side responder for the M-stage store/load interface: consumes byte-enabled writes
//  (addr/wdata/byteen) into a word-addressed data memory. Serves loads with a registered
//  1-cycle read, and sign/zero-extends the result for the W stage.

---
 rtl/dm_load_responder_pkg.sv | 28 ++
 rtl/dm_load_responder_load_ext.sv | 29 ++
 rtl/dm_load_responder.sv | 123 ++++++++++++
 tb/tb_dm_load_responder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/dm_load_responder_pkg.sv
// Shared load-op codes and address-region bounds for the M-stage memory responder
// and the store-side byte-enable unit.
package dm_load_responder_pkg;

    typedef enum logic [2:0] {
        DE_none = 3'd0,
        DE_lw   = 3'd1,
        DE_lh   = 3'd2,
        DE_lhu  = 3'd3,
        DE_lb   = 3'd4,
        DE_lbu  = 3'd5
    } ld_op_e;

    localparam logic [31:0] DM_START  = 32'h0000_0000;
    localparam logic [31:0] DM_END    = 32'h0000_2fff;
    localparam logic [31:0] T0_START  = 32'h0000_7f00;
    localparam logic [31:0] T0_END    = 32'h0000_7f0b;
    localparam logic [31:0] T1_START  = 32'h0000_7f10;
    localparam logic [31:0] T1_END    = 32'h0000_7f1b;
    localparam logic [31:0] IRQ_START = 32'h0000_7f20;
    localparam logic [31:0] IRQ_END   = 32'h0000_7f23;

    function automatic logic in_range(input logic [31:0] a, input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/dm_load_responder_load_ext.sv
// Combinational load-result extension: picks the half/byte lane selected by the
// low address bits and sign- or zero-extends it.
module load_ext
    import dm_load_responder_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lo,
    input  logic [2:0]  op,
    output logic [31:0] data
);

    logic [15:0] half;
    logic [7:0]  byte_sel;

    always_comb begin
        half     = lo[1] ? word[31:16] : word[15:0];
        byte_sel = word[8*lo +: 8];
        data     = 32'd0;
        case (ld_op_e'(op))
            DE_lw:   data = word;
            DE_lh:   data = {{16{half[15]}}, half};
            DE_lhu:  data = {16'd0, half};
            DE_lb:   data = {{24{byte_sel[7]}}, byte_sel};
            DE_lbu:  data = {24'd0, byte_sel};
            default: data = 32'd0;
        endcase
    end

endmodule

// File: rtl/dm_load_responder.sv
// M-stage data-memory responder: byte-enabled stores, 1-cycle registered loads,
// device forwarding and AdEL detection. Optional write trace: DMEM_WRITE_LOG_EN.
module dm_load_responder
    import dm_load_responder_pkg::*;
#(
    parameter int DM_WORDS = 3072
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    input  logic [3:0]  m_byteen,
    input  logic [2:0]  ld_op,
    input  logic        ov_load,
    input  logic        flush,
    output logic [31:0] dev_addr,
    output logic        dev_we,
    output logic [31:0] dev_wdata,
    input  logic [31:0] dev_rdata,
    output logic        exc_adel,
    output logic [31:0] w_rdata,
    output logic        w_rvalid
);

    logic [31:0] mem_q [DM_WORDS];

    logic [31:0] rd_word_q, rd_word_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  lo_q, lo_d;
    logic        w_rvalid_q, w_rvalid_d;

    logic        in_dm, in_t0, in_t1, in_irq, in_dev;
    logic        ld, is_lw, is_half, is_sub_word, capture, dm_we;
    logic [11:0] idx;
    logic [31:0] merged_word;

    always_comb begin
        in_dm   = in_range(m_addr, DM_START, DM_END);
        in_t0   = in_range(m_addr, T0_START, T0_END);
        in_t1   = in_range(m_addr, T1_START, T1_END);
        in_irq  = in_range(m_addr, IRQ_START, IRQ_END);
        in_dev  = in_t0 | in_t1 | in_irq;
        idx     = m_addr[13:2];

        ld          = m_valid && (ld_op_e'(ld_op) != DE_none);
        is_lw       = ld_op_e'(ld_op) == DE_lw;
        is_half     = (ld_op_e'(ld_op) == DE_lh) || (ld_op_e'(ld_op) == DE_lhu);
        is_sub_word = is_half || (ld_op_e'(ld_op) == DE_lb) || (ld_op_e'(ld_op) == DE_lbu);

        // Timer registers are word-only; the IRQ window tolerates narrow loads.
        exc_adel = ld && (ov_load
                          || (is_lw && (m_addr[1:0] != 2'b00))
                          || (is_half && m_addr[0])
                          || !(in_dm || in_dev)
                          || (is_sub_word && (in_t0 || in_t1)));

        dm_we     = m_valid && !flush && in_dm && (m_byteen != 4'b0000);
        dev_we    = m_valid && !flush && in_dev && (m_byteen == 4'b1111);
        dev_addr  = m_addr;
        dev_wdata = m_wdata;

        merged_word = mem_q[idx];
        for (int k = 0; k < 4; k++) begin
            if (m_byteen[k]) merged_word[8*k +: 8] = m_wdata[8*k +: 8];
        end

        capture    = ld && !flush && !exc_adel;
        rd_word_d  = rd_word_q;
        op_d       = DE_none;
        lo_d       = lo_q;
        w_rvalid_d = 1'b0;
        if (capture) begin
            rd_word_d  = in_dm ? mem_q[idx] : dev_rdata;
            op_d       = ld_op;
            lo_d       = m_addr[1:0];
            w_rvalid_d = 1'b1;
        end
    end

    // NOTE: the memory array has no reset; resetting thousands of words would
    // prevent RAM inference and nothing depends on its power-up contents.
    always_ff @(posedge clk) begin
        if (dm_we) mem_q[idx] <= merged_word;
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_word_q  <= 32'd0;
            op_q       <= DE_none;
            lo_q       <= 2'd0;
            w_rvalid_q <= 1'b0;
        end else begin
            rd_word_q  <= rd_word_d;
            op_q       <= op_d;
            lo_q       <= lo_d;
            w_rvalid_q <= w_rvalid_d;
        end
    end

    load_ext u_load_ext (
        .word (rd_word_q),
        .lo   (lo_q),
        .op   (op_q),
        .data (w_rdata)
    );

    assign w_rvalid = w_rvalid_q;

`ifdef DMEM_WRITE_LOG_EN
    always_ff @(posedge clk) begin
        if (reset && dm_we)
            $display("%d@%h: *%h <= %h", $time, m_pc, {m_addr[31:2], 2'b00}, merged_word);
    end
`else
    logic unused_pc;
    assign unused_pc = ^m_pc;
`endif

endmodule

// File: tb/tb_dm_load_responder.sv
// Directed self-checking bench for dm_load_responder: stores, extended loads,
// address errors, device forwarding, flush and reset behaviour.
module tb_dm_load_responder;
    import dm_load_responder_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_byteen;
    logic [2:0]  ld_op;
    logic        ov_load;
    logic        flush;
    logic [31:0] dev_addr;
    logic        dev_we;
    logic [31:0] dev_wdata;
    logic [31:0] dev_rdata;
    logic        exc_adel;
    logic [31:0] w_rdata;
    logic        w_rvalid;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dm_load_responder dut (
        .clk       (clk),
        .reset     (reset),
        .m_valid   (m_valid),
        .m_pc      (m_pc),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_byteen  (m_byteen),
        .ld_op     (ld_op),
        .ov_load   (ov_load),
        .flush     (flush),
        .dev_addr  (dev_addr),
        .dev_we    (dev_we),
        .dev_wdata (dev_wdata),
        .dev_rdata (dev_rdata),
        .exc_adel  (exc_adel),
        .w_rdata   (w_rdata),
        .w_rvalid  (w_rvalid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge and settle 1 unit before checks.
    task automatic drive(input logic v, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input ld_op_e op, input logic ov,
                         input logic fl);
        m_valid  = v;
        m_addr   = addr;
        m_wdata  = wdata;
        m_byteen = be;
        ld_op    = op;
        ov_load  = ov;
        flush    = fl;
        m_pc     = m_pc + 32'd4;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 32'd0, 4'b0000, DE_none, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_check(input string tag, input logic [31:0] addr, input ld_op_e op,
                              input logic [31:0] exp);
        drive(1'b1, addr, 32'd0, 4'b0000, op, 1'b0, 1'b0);
        check({tag, "_adel"}, {31'd0, exc_adel}, 32'd0);
        tick();
        check({tag, "_rvalid"}, {31'd0, w_rvalid}, 32'd1);
        check({tag, "_rdata"}, w_rdata, exp);
    endtask

    task automatic adel_check(input string tag, input logic [31:0] addr, input ld_op_e op,
                              input logic ov, input logic exp);
        drive(1'b1, addr, 32'd0, 4'b0000, op, ov, 1'b0);
        check(tag, {31'd0, exc_adel}, {31'd0, exp});
        tick();
        check({tag, "_rvalid"}, {31'd0, w_rvalid}, {31'd0, !exp});
    endtask

    initial begin
        m_pc      = 32'h0000_3000;
        dev_rdata = 32'h0;
        reset     = 1'b0;
        idle();
        repeat (3) tick();
        check("rst_rvalid", {31'd0, w_rvalid}, 32'd0);
        check("rst_rdata", w_rdata, 32'd0);
        reset = 1'b1;
        tick();

        // sw then lw of the same word
        drive(1'b1, 32'h10, 32'h1234_5678, 4'b1111, DE_none, 1'b0, 1'b0);
        check("sw_dm_devwe", {31'd0, dev_we}, 32'd0);
        check("sw_dm_adel", {31'd0, exc_adel}, 32'd0);
        tick();
        load_check("lw10", 32'h10, DE_lw, 32'h1234_5678);
        idle();
        tick();
        check("lw10_one_cycle", {31'd0, w_rvalid}, 32'd0);

        // byte store and extended loads
        drive(1'b1, 32'h11, 32'h0000_AB00, 4'b0010, DE_none, 1'b0, 1'b0);
        tick();
        load_check("lb11", 32'h11, DE_lb, 32'hFFFF_FFAB);
        load_check("lbu11", 32'h11, DE_lbu, 32'h0000_00AB);
        load_check("lw10b", 32'h10, DE_lw, 32'h1234_AB78);
        load_check("lh12", 32'h12, DE_lh, 32'h0000_1234);
        load_check("lh10", 32'h10, DE_lh, 32'hFFFF_AB78);
        load_check("lhu10", 32'h10, DE_lhu, 32'h0000_AB78);
        load_check("lb13", 32'h13, DE_lb, 32'h0000_0012);

        // address errors and region boundaries
        adel_check("adel_lh13", 32'h13, DE_lh, 1'b0, 1'b1);
        adel_check("adel_lw12", 32'h12, DE_lw, 1'b0, 1'b1);
        adel_check("adel_lb7f04", 32'h7f04, DE_lb, 1'b0, 1'b1);
        adel_check("adel_lw3000", 32'h3000, DE_lw, 1'b0, 1'b1);
        adel_check("adel_ov", 32'h10, DE_lw, 1'b1, 1'b1);
        adel_check("ok_lw2ffc", 32'h2ffc, DE_lw, 1'b0, 1'b0);
        adel_check("ok_lb7f21", 32'h7f21, DE_lb, 1'b0, 1'b0);
        adel_check("adel_lw7f0c", 32'h7f0c, DE_lw, 1'b0, 1'b1);

        // device load and store
        dev_rdata = 32'hCAFE_0001;
        load_check("lw7f04", 32'h7f04, DE_lw, 32'hCAFE_0001);
        dev_rdata = 32'h0;
        drive(1'b1, 32'h7f00, 32'h5555_AAAA, 4'b1111, DE_none, 1'b0, 1'b0);
        check("sw7f00_devwe", {31'd0, dev_we}, 32'd1);
        check("sw7f00_addr", dev_addr, 32'h7f00);
        check("sw7f00_wdata", dev_wdata, 32'h5555_AAAA);
        tick();
        idle();
        check("devwe_drop", {31'd0, dev_we}, 32'd0);
        drive(1'b1, 32'h7f10, 32'h0000_AAAA, 4'b0011, DE_none, 1'b0, 1'b0);
        check("partial_devwe", {31'd0, dev_we}, 32'd0);
        drive(1'b1, 32'h7f10, 32'h5555_AAAA, 4'b1111, DE_none, 1'b0, 1'b1);
        check("flush_devwe", {31'd0, dev_we}, 32'd0);
        tick();

        // flush kills stores and loads; AdEL still reported
        drive(1'b1, 32'h20, 32'h1111_2222, 4'b1111, DE_none, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h20, 32'hDEAD_BEEF, 4'b1111, DE_none, 1'b0, 1'b1);
        tick();
        load_check("lw20_after_flush", 32'h20, DE_lw, 32'h1111_2222);
        drive(1'b1, 32'h20, 32'd0, 4'b0000, DE_lw, 1'b0, 1'b1);
        tick();
        check("flush_lw_rvalid", {31'd0, w_rvalid}, 32'd0);
        drive(1'b1, 32'h21, 32'd0, 4'b0000, DE_lw, 1'b0, 1'b1);
        check("flush_adel", {31'd0, exc_adel}, 32'd1);
        tick();

        // reset right after a load is captured
        drive(1'b1, 32'h10, 32'd0, 4'b0000, DE_lw, 1'b0, 1'b0);
        tick();
        idle();
        check("pre_rst_rvalid", {31'd0, w_rvalid}, 32'd1);
        reset = 1'b0;
        #1;
        check("midrst_rvalid", {31'd0, w_rvalid}, 32'd0);
        check("midrst_rdata", w_rdata, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_rvalid", {31'd0, w_rvalid}, 32'd0);
        check("post_rst_rdata", w_rdata, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
